// File: rtl/edram_port_pkg.sv
// Shared types and interface widths for the IMA-side EDRAM port.
package edram_port_pkg;

  localparam int unsigned EdramAddrWidth = 16;
  localparam int unsigned EdramDataWidth = 16;

  typedef enum logic [1:0] {
    IDLE,
    WDAT,
    REQ,
    XFER
  } port_state_t;

endpackage

// File: rtl/sat_counter.sv
// Free-running incrementer that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {Width{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/edram_port.sv
// IMA-side burst initiator toward the shared EDRAM controller: one word per
// request/wait handshake, with per-word timeout and stall statistics.
module edram_port
  import edram_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = EdramAddrWidth,
  parameter int unsigned DATA_WIDTH = EdramDataWidth,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ima_ren,
  output logic                  ima_wen,
  output logic [ADDR_WIDTH-1:0] ima_addr,
  output logic [DATA_WIDTH-1:0] ima_data,
  input  logic                  ima_wait,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           stall_cnt
);

  // Counter only ever holds values below TIMEOUT.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  port_state_t           state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  done_q, done_d;
  logic [CntW-1:0]       wcnt_q, wcnt_d;

  logic        in_req;
  logic        complete;
  logic        timeout_hit;
  logic        req_on;
  logic [31:0] wcnt_ext;

  always_comb begin
    in_req      = (state_q == REQ) || (state_q == XFER);
    // Only an armed port may treat wait=0 as service.
    complete    = (state_q == XFER) && !ima_wait;
    wcnt_ext    = 32'(wcnt_q);
    timeout_hit = (TIMEOUT != 0) && in_req && !complete && (wcnt_ext == TIMEOUT - 1);
    req_on      = in_req && !complete && !timeout_hit;
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    wcnt_d   = in_req ? wcnt_q + 1'b1 : '0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = cmd_write ? WDAT : REQ;
        end
      end
      WDAT: begin
        if (wdata_valid) begin
          data_d  = wdata;
          state_d = REQ;
        end
      end
      REQ: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (ima_wait) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (complete) begin
          wcnt_d = '0;
          if (!write_q) begin
            rdata_d  = ram_rdata;
            rvalid_d = 1'b1;
          end
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = write_q ? WDAT : REQ;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      wcnt_q   <= wcnt_d;
    end
  end

  sat_counter #(
    .Width(32)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (in_req),
    .count(stall_cnt)
  );

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WDAT);
  assign busy        = (state_q != IDLE);
  assign ima_ren     = req_on && !write_q;
  assign ima_wen     = req_on && write_q;
  assign ima_addr    = addr_q;
  assign ima_data    = data_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign done        = done_q;
  assign err         = timeout_hit;

endmodule

// File: tb/tb_edram_port.sv
// Directed bench for edram_port; the controller's wait line is scripted per cycle.
module tb_edram_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [15:0] wdata = '0;
  logic        rdata_valid;
  logic [15:0] rdata;
  logic        ima_ren;
  logic        ima_wen;
  logic [15:0] ima_addr;
  logic [15:0] ima_data;
  logic        ima_wait = 1'b0;
  logic [15:0] ram_rdata = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_stall = '0;

  always #5 clk = ~clk;

  edram_port #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .LEN_WIDTH (4),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .ima_ren    (ima_ren),
    .ima_wen    (ima_wen),
    .ima_addr   (ima_addr),
    .ima_data   (ima_data),
    .ima_wait   (ima_wait),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .stall_cnt  (stall_cnt)
  );

  // Inputs change 2 ns after the edge; outputs are checked 1 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    settle();
    n_cmp++;
    if ({cmd_ready, busy, ima_ren, ima_wen, rdata_valid, done, err} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {cmd_ready, busy, ima_ren, ima_wen, rdata_valid, done, err});
    end
    n_cmp++;
    if ({ima_addr, ima_data, rdata} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {ima_addr, ima_data, rdata});
    end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stall: got %0d want 0", stall_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    ima_wait = 1'b1;
    settle();
    n_cmp++;
    if ({ima_ren, ima_wen, ima_addr} !== {2'b10, 16'h0010}) begin
      n_bad++;
      $display("FAIL load_req: got ren=%b wen=%b addr=%h want 1 0 0010",
               ima_ren, ima_wen, ima_addr);
    end
    tick();
    tick();
    tick();
    ima_wait = 1'b0; ram_rdata = 16'hBEEF;
    settle();
    n_cmp++;
    if ({ima_ren, rdata_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL load_complete_ren: got ren=%b rv=%b want 0 0", ima_ren, rdata_valid);
    end
    tick();
    ram_rdata = 16'h0000;
    settle();
    n_cmp++;
    if ({rdata_valid, rdata, done, busy} !== {1'b1, 16'hBEEF, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL load_rdata: got rv=%b rdata=%h done=%b busy=%b want 1 beef 1 0",
               rdata_valid, rdata, done, busy);
    end
    tick();
    settle();
    exp_stall += 32'd4;
    n_cmp++;
    if ({rdata_valid, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL load_pulse_len: got rv=%b done=%b want 0 0", rdata_valid, done);
    end
    n_cmp++;
    if (stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL load_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_store_wrap();
    logic [15:0] ea;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'hFFFE; cmd_len = 4'd2;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ea = 16'hFFFE + 16'(i);
      settle();
      n_cmp++;
      if ({wdata_ready, done} !== 2'b10) begin
        n_bad++;
        $display("FAIL store_wdat%0d: got wready=%b done=%b want 1 0", i, wdata_ready, done);
      end
      wdata_valid = 1'b1; wdata = 16'(i + 1);
      tick();
      wdata_valid = 1'b0;
      ima_wait = 1'b1;
      settle();
      n_cmp++;
      if ({ima_wen, ima_ren, ima_addr, ima_data} !== {2'b10, ea, 16'(i + 1)}) begin
        n_bad++;
        $display("FAIL store_word%0d: got wen=%b ren=%b addr=%h data=%h want 1 0 %h %h",
                 i, ima_wen, ima_ren, ima_addr, ima_data, ea, 16'(i + 1));
      end
      tick();
      ima_wait = 1'b0;
      settle();
      n_cmp++;
      if (ima_wen !== 1'b0) begin
        n_bad++;
        $display("FAIL store_drop%0d: got wen=%b want 0", i, ima_wen);
      end
      tick();
    end
    settle();
    exp_stall += 32'd6;
    n_cmp++;
    if ({done, cmd_ready, rdata_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL store_done: got done=%b ready=%b rv=%b want 1 1 0",
               done, cmd_ready, rdata_valid);
    end
    tick();
    settle();
    n_cmp++;
    if (stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL store_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_last_served();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020; cmd_len = 4'd0;
    ima_wait = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_cmp++;
      if ({ima_ren, rdata_valid, done} !== 3'b100) begin
        n_bad++;
        $display("FAIL lastsrv_hold%0d: got ren=%b rv=%b done=%b want 1 0 0",
                 c, ima_ren, rdata_valid, done);
      end
      tick();
    end
    ima_wait = 1'b1;
    tick();
    ima_wait = 1'b0; ram_rdata = 16'h1234;
    tick();
    ram_rdata = 16'h0000;
    settle();
    exp_stall += 32'd7;
    n_cmp++;
    if ({rdata_valid, rdata, done} !== {1'b1, 16'h1234, 1'b1}) begin
      n_bad++;
      $display("FAIL lastsrv_rdata: got rv=%b rdata=%h done=%b want 1 1234 1",
               rdata_valid, rdata, done);
    end
    tick();
    settle();
    n_cmp++;
    if (stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL lastsrv_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_other_ima_first();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    ima_wait = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_cmp++;
      if ({ima_ren, rdata_valid} !== 2'b10) begin
        n_bad++;
        $display("FAIL other_hold%0d: got ren=%b rv=%b want 1 0", c, ima_ren, rdata_valid);
      end
      tick();
    end
    ima_wait = 1'b0; ram_rdata = 16'hCAFE;
    tick();
    ram_rdata = 16'h0000;
    settle();
    exp_stall += 32'd5;
    n_cmp++;
    if ({rdata_valid, rdata, done} !== {1'b1, 16'hCAFE, 1'b1}) begin
      n_bad++;
      $display("FAIL other_rdata: got rv=%b rdata=%h done=%b want 1 cafe 1",
               rdata_valid, rdata, done);
    end
    n_cmp++;
    if (stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL other_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
    tick();
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'hDEAD; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    ima_wait = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      settle();
      n_cmp++;
      if ({ima_ren, err} !== ((c < 8) ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL timeout_cyc%0d: got ren=%b err=%b want %b",
                 c, ima_ren, err, ((c < 8) ? 2'b10 : 2'b01));
      end
      tick();
    end
    settle();
    exp_stall += 32'd8;
    n_cmp++;
    if ({cmd_ready, busy, err, done, ima_ren, rdata_valid} !== 6'b100000) begin
      n_bad++;
      $display("FAIL timeout_idle: got %b want 100000",
               {cmd_ready, busy, err, done, ima_ren, rdata_valid});
    end
    n_cmp++;
    if (stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL timeout_stall: got %0d want %0d", stall_cnt, exp_stall);
    end
    ima_wait = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    ima_wait = 1'b1;
    tick();
    ima_wait = 1'b0; ram_rdata = 16'h1111;
    tick();
    settle();
    n_cmp++;
    if ({ima_ren, ima_addr, rdata_valid} !== {1'b1, 16'h0041, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_word2: got ren=%b addr=%h rv=%b want 1 0041 1",
               ima_ren, ima_addr, rdata_valid);
    end
    ima_wait = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ima_wait = 1'b0;
    settle();
    n_cmp++;
    if ({cmd_ready, busy, ima_ren, ima_wen, rdata_valid, done, err} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL midrst_ctrl: got %b want 1000000",
               {cmd_ready, busy, ima_ren, ima_wen, rdata_valid, done, err});
    end
    n_cmp++;
    if ({ima_addr, rdata, stall_cnt} !== 64'h0) begin
      n_bad++;
      $display("FAIL midrst_data: got addr=%h rdata=%h stall=%0d want 0 0 0",
               ima_addr, rdata, stall_cnt);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0055; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 16'h00A5;
    tick();
    wdata_valid = 1'b0;
    ima_wait = 1'b1;
    settle();
    n_cmp++;
    if ({ima_wen, ima_addr, ima_data} !== {1'b1, 16'h0055, 16'h00A5}) begin
      n_bad++;
      $display("FAIL midrst_new_req: got wen=%b addr=%h data=%h want 1 0055 00a5",
               ima_wen, ima_addr, ima_data);
    end
    tick();
    ima_wait = 1'b0;
    tick();
    settle();
    n_cmp++;
    if ({done, stall_cnt} !== {1'b1, 32'd2}) begin
      n_bad++;
      $display("FAIL midrst_new_done: got done=%b stall=%0d want 1 2", done, stall_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_load();
    test_store_wrap();
    test_last_served();
    test_other_ima_first();
    test_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
